// File: rtl/maq_pkg.sv
// Shared constants and types for the clock counting stages (seconds and minutes/hours).
// Digit limits are typed to the width of the digit they bound.
package maq_pkg;

    localparam logic [2:0] MIN_MSD_MAX    = 3'd5;
    localparam logic [3:0] LSD_MAX        = 4'd9;
    localparam logic [1:0] HOUR24_MAX_MSD = 2'd2;
    localparam logic [3:0] HOUR24_MAX_LSD = 4'd3;
    localparam int         HOUR12_MAX     = 12;

    localparam logic [1:0] HOUR12_MAX_MSD = 2'(HOUR12_MAX / 10);
    localparam logic [3:0] HOUR12_MAX_LSD = 4'(HOUR12_MAX % 10);

    // Index of each edge-detected input in the event vector
    typedef enum logic [1:0] {
        EV_ADDMINUTO = 2'd0,
        EV_INC_MIN   = 2'd1,
        EV_INC_HOUR  = 2'd2
    } maq_event_e;

    localparam int NUM_EVENTS = 3;

    typedef struct packed {
        logic       pm;
        logic [1:0] hour_msd;
        logic [3:0] hour_lsd;
        logic [2:0] min_msd;
        logic [3:0] min_lsd;
    } maq_time_t;

endpackage

// File: rtl/maq_mh_if.sv
// Control inputs and BCD display outputs of the minutes/hours stage.
// master drives the controls, slave is the counter.
interface maq_mh_if;

    logic       maqmh_addminuto;
    logic       maqmh_set_mode;
    logic       maqmh_inc_min;
    logic       maqmh_inc_hour;
    logic [3:0] maqmh_min_Lsd;
    logic [2:0] maqmh_min_Msd;
    logic [3:0] maqmh_hour_Lsd;
    logic [1:0] maqmh_hour_Msd;
    logic       maqmh_pm;
    logic       maqmh_adddia;

    modport master (
        output maqmh_addminuto, maqmh_set_mode, maqmh_inc_min, maqmh_inc_hour,
        input  maqmh_min_Lsd, maqmh_min_Msd, maqmh_hour_Lsd, maqmh_hour_Msd,
               maqmh_pm, maqmh_adddia
    );

    modport slave (
        input  maqmh_addminuto, maqmh_set_mode, maqmh_inc_min, maqmh_inc_hour,
        output maqmh_min_Lsd, maqmh_min_Msd, maqmh_hour_Lsd, maqmh_hour_Msd,
               maqmh_pm, maqmh_adddia
    );

endinterface

// File: rtl/maq_edge.sv
// Rising-edge detector: combinational one-cycle pulse when din is high after a sampled low.
// A level already high when reset releases is not counted until it has been seen low.
module maq_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    logic prev_q;
    logic prev_d;
    logic armed_q;
    logic armed_d;

    always_comb begin
        prev_d  = din;
        armed_d = armed_q | ~din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            prev_q  <= prev_d;
            armed_q <= armed_d;
        end
    end

    assign rise = din & ~prev_q & armed_q;

endmodule

// File: rtl/maq_mh.sv
// Minutes/hours counter of the digital clock: BCD digits, 24 h or 12 h hours,
// set-time buttons and a one-cycle day-rollover pulse.
module maq_mh
    import maq_pkg::*;
#(
    parameter bit FORMAT_24H = 1'b1
) (
    input  logic        maqmh_clock,
    input  logic        maqmh_reset,
    maq_mh_if.slave     bus
);

    localparam maq_time_t RESET_TIME = FORMAT_24H ? 14'd0
        : {1'b0, HOUR12_MAX_MSD, HOUR12_MAX_LSD, 3'd0, 4'd0};

    logic [NUM_EVENTS-1:0] ev_in;
    logic [NUM_EVENTS-1:0] ev_rise;

    assign ev_in[EV_ADDMINUTO] = bus.maqmh_addminuto;
    assign ev_in[EV_INC_MIN]   = bus.maqmh_inc_min;
    assign ev_in[EV_INC_HOUR]  = bus.maqmh_inc_hour;

    // History updates in every mode, so a button held across a mode change never fires
    generate
        for (genvar gi = 0; gi < NUM_EVENTS; gi++) begin : g_edge
            maq_edge u_edge (
                .clk  (maqmh_clock),
                .rst_n(maqmh_reset),
                .din  (ev_in[gi]),
                .rise (ev_rise[gi])
            );
        end
    endgenerate

    function automatic maq_time_t inc_minute(input maq_time_t t);
        maq_time_t r;
        r = t;
        if (t.min_lsd == LSD_MAX) begin
            r.min_lsd = 4'd0;
            r.min_msd = (t.min_msd == MIN_MSD_MAX) ? 3'd0 : t.min_msd + 3'd1;
        end else begin
            r.min_lsd = t.min_lsd + 4'd1;
        end
        return r;
    endfunction

    function automatic maq_time_t inc_hour(input maq_time_t t);
        maq_time_t r;
        r = t;
        if (FORMAT_24H) begin
            if (t.hour_msd == HOUR24_MAX_MSD && t.hour_lsd == HOUR24_MAX_LSD) begin
                r.hour_msd = 2'd0;
                r.hour_lsd = 4'd0;
            end else if (t.hour_lsd == LSD_MAX) begin
                r.hour_msd = t.hour_msd + 2'd1;
                r.hour_lsd = 4'd0;
            end else begin
                r.hour_lsd = t.hour_lsd + 4'd1;
            end
        end else begin
            // 11 -> 12 is where AM/PM flips; 12 -> 01 keeps the flag
            if (t.hour_msd == HOUR12_MAX_MSD && t.hour_lsd == HOUR12_MAX_LSD - 4'd1) begin
                r.hour_lsd = HOUR12_MAX_LSD;
                r.pm       = ~t.pm;
            end else if (t.hour_msd == HOUR12_MAX_MSD && t.hour_lsd == HOUR12_MAX_LSD) begin
                r.hour_msd = 2'd0;
                r.hour_lsd = 4'd1;
            end else if (t.hour_lsd == LSD_MAX) begin
                r.hour_msd = t.hour_msd + 2'd1;
                r.hour_lsd = 4'd0;
            end else begin
                r.hour_lsd = t.hour_lsd + 4'd1;
            end
        end
        return r;
    endfunction

    maq_time_t time_q;
    maq_time_t time_d;
    logic      adddia_q;
    logic      adddia_d;

    logic run_mode;
    logic min_last;
    logic hour_last;
    logic min_tick;
    logic hour_tick;

    always_comb begin
        run_mode  = ~bus.maqmh_set_mode;
        min_last  = (time_q.min_msd == MIN_MSD_MAX) && (time_q.min_lsd == LSD_MAX);
        hour_last = FORMAT_24H
            ? (time_q.hour_msd == HOUR24_MAX_MSD && time_q.hour_lsd == HOUR24_MAX_LSD)
            : (time_q.hour_msd == HOUR12_MAX_MSD && time_q.hour_lsd == HOUR12_MAX_LSD - 4'd1
               && time_q.pm);

        // Set mode: buttons act independently and the minute wrap never carries
        min_tick  = run_mode ? ev_rise[EV_ADDMINUTO] : ev_rise[EV_INC_MIN];
        hour_tick = run_mode ? (ev_rise[EV_ADDMINUTO] & min_last) : ev_rise[EV_INC_HOUR];

        time_d = time_q;
        if (min_tick) begin
            time_d = inc_minute(time_d);
        end
        if (hour_tick) begin
            time_d = inc_hour(time_d);
        end
        adddia_d = run_mode & ev_rise[EV_ADDMINUTO] & min_last & hour_last;
    end

    always_ff @(posedge maqmh_clock or negedge maqmh_reset) begin
        if (!maqmh_reset) begin
            time_q   <= RESET_TIME;
            adddia_q <= 1'b0;
        end else begin
            time_q   <= time_d;
            adddia_q <= adddia_d;
        end
    end

    assign bus.maqmh_min_Lsd  = time_q.min_lsd;
    assign bus.maqmh_min_Msd  = time_q.min_msd;
    assign bus.maqmh_hour_Lsd = time_q.hour_lsd;
    assign bus.maqmh_hour_Msd = time_q.hour_msd;
    assign bus.maqmh_pm       = FORMAT_24H ? 1'b0 : time_q.pm;
    assign bus.maqmh_adddia   = adddia_q;

endmodule
